// File: rtl/memory_stage.sv
// Memory stage of a five-stage pipeline: passes ALU results through, issues
// variable-latency loads, aligns/extends load data, and commits HI/LO on hand-off.
module memory_stage #(
  parameter logic [31:0] HILO_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exe_valid,
  input  logic        exe_reg_en,
  input  logic        exe_mem_read,
  input  logic        exe_double_en,
  input  logic [2:0]  exe_mem_op,
  input  logic [5:0]  exe_reg_waddr,
  input  logic [31:0] exe_alu_result,
  input  logic [31:0] exe_HI_wdata,
  input  logic [31:0] exe_LO_wdata,
  output logic        mem_allowin,
  output logic        data_req,
  output logic [31:0] data_addr,
  input  logic        data_ack,
  input  logic [31:0] data_rdata,
  input  logic        wb_allowin,
  output logic        mem_valid,
  output logic        mem_reg_en,
  output logic [5:0]  mem_reg_waddr,
  output logic [31:0] mem_reg_wdata,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;

  state_t      state, state_next;
  logic [2:0]  mem_op_q;
  logic [1:0]  off_q;
  logic        double_q;
  logic [31:0] hi_wdata_q, lo_wdata_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        accept, consume;

  assign mem_allowin = (state == S_IDLE) | ((state == S_DONE) & wb_allowin);
  assign accept      = exe_valid & mem_allowin;
  assign consume     = (state == S_DONE) & wb_allowin;
  assign mem_valid   = (state == S_DONE);
  // The request is exactly the outstanding-load state, so it drops on the ack edge.
  assign data_req    = (state == S_WAIT);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic: accept refills the stage in the same edge it is consumed.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      S_IDLE: if (exe_valid) state_next = exe_mem_read ? S_WAIT : S_DONE;
      S_WAIT: if (data_ack) state_next = S_DONE;
      S_DONE: if (wb_allowin) begin
        if (exe_valid) state_next = exe_mem_read ? S_WAIT : S_DONE;
        else           state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Load alignment and extension from the latched byte offset and load type.
  always_comb begin
    byte_sel = data_rdata[7:0];
    case (off_q)
      2'd1:    byte_sel = data_rdata[15:8];
      2'd2:    byte_sel = data_rdata[23:16];
      2'd3:    byte_sel = data_rdata[31:24];
      default: byte_sel = data_rdata[7:0];
    endcase
    half_sel = off_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (mem_op_q)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0, half_sel};
      default: load_data = data_rdata;
    endcase
  end

  // Instruction fields: latched on accept; load result captured on the ack edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_reg_en    <= 1'b0;
      mem_reg_waddr <= 6'd0;
      mem_reg_wdata <= 32'h0;
      data_addr     <= 32'h0;
      mem_op_q      <= 3'd0;
      off_q         <= 2'd0;
      double_q      <= 1'b0;
      hi_wdata_q    <= 32'h0;
      lo_wdata_q    <= 32'h0;
    end else if (accept) begin
      mem_reg_en    <= exe_reg_en;
      mem_reg_waddr <= exe_reg_waddr;
      mem_op_q      <= exe_mem_op;
      off_q         <= exe_alu_result[1:0];
      double_q      <= exe_double_en;
      hi_wdata_q    <= exe_HI_wdata;
      lo_wdata_q    <= exe_LO_wdata;
      if (exe_mem_read) data_addr     <= {exe_alu_result[31:2], 2'b00};
      else              mem_reg_wdata <= exe_alu_result;
    end else if ((state == S_WAIT) && data_ack) begin
      mem_reg_wdata <= load_data;
    end
  end

  // HI/LO commit only when the owning instruction leaves the stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_out <= HILO_INIT;
      lo_out <= HILO_INIT;
    end else if (consume && double_q) begin
      hi_out <= hi_wdata_q;
      lo_out <= lo_wdata_q;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: transaction-level model plus directed vectors.
module tb_memory_stage;

  localparam logic [31:0] INIT  = 32'h5555_AAAA;
  localparam logic [31:0] RDATA = 32'h80FF_1122;

  logic        clk = 1'b0;
  logic        resetn;
  logic        exe_valid, exe_reg_en, exe_mem_read, exe_double_en;
  logic [2:0]  exe_mem_op;
  logic [5:0]  exe_reg_waddr;
  logic [31:0] exe_alu_result, exe_HI_wdata, exe_LO_wdata;
  logic        mem_allowin, data_req, data_ack, wb_allowin;
  logic [31:0] data_addr, data_rdata;
  logic        mem_valid, mem_reg_en;
  logic [5:0]  mem_reg_waddr;
  logic [31:0] mem_reg_wdata, hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  memory_stage #(.HILO_INIT(INIT)) dut (
    .clk(clk), .resetn(resetn),
    .exe_valid(exe_valid), .exe_reg_en(exe_reg_en), .exe_mem_read(exe_mem_read),
    .exe_double_en(exe_double_en), .exe_mem_op(exe_mem_op), .exe_reg_waddr(exe_reg_waddr),
    .exe_alu_result(exe_alu_result), .exe_HI_wdata(exe_HI_wdata), .exe_LO_wdata(exe_LO_wdata),
    .mem_allowin(mem_allowin), .data_req(data_req), .data_addr(data_addr),
    .data_ack(data_ack), .data_rdata(data_rdata), .wb_allowin(wb_allowin),
    .mem_valid(mem_valid), .mem_reg_en(mem_reg_en), .mem_reg_waddr(mem_reg_waddr),
    .mem_reg_wdata(mem_reg_wdata), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load result: shift the word, mask, and sign-extend arithmetically.
  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * off[1])) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return h;
      default: return rd;
    endcase
  endfunction

  // Model: whether the stage holds an instruction, whether its load is pending,
  // and the result/architectural values it must present.
  logic        m_holding, m_loading, m_en, m_dbl;
  logic [5:0]  m_waddr;
  logic [2:0]  m_op;
  logic [1:0]  m_off;
  logic [31:0] m_wdata, m_addr, m_hi_w, m_lo_w, m_hi, m_lo;

  always @(posedge clk or negedge resetn) begin
    logic handed_off, room;
    if (!resetn) begin
      m_holding = 0; m_loading = 0; m_en = 0; m_dbl = 0; m_waddr = 0; m_op = 0; m_off = 0;
      m_wdata = 0; m_addr = 0; m_hi_w = 0; m_lo_w = 0; m_hi = INIT; m_lo = INIT;
    end else begin
      handed_off = m_holding && !m_loading && wb_allowin;
      room       = !m_holding || handed_off;
      if (handed_off && m_dbl) begin
        m_hi = m_hi_w;
        m_lo = m_lo_w;
      end
      if (m_loading) begin
        if (data_ack) begin
          m_wdata   = model_load(m_op, m_off, data_rdata);
          m_loading = 0;
        end
      end else if (exe_valid && room) begin
        m_holding = 1;
        m_loading = exe_mem_read;
        m_en = exe_reg_en; m_waddr = exe_reg_waddr; m_op = exe_mem_op; m_dbl = exe_double_en;
        m_off = exe_alu_result[1:0]; m_hi_w = exe_HI_wdata; m_lo_w = exe_LO_wdata;
        if (exe_mem_read) m_addr  = exe_alu_result & 32'hFFFF_FFFC;
        else              m_wdata = exe_alu_result;
      end else if (handed_off) begin
        m_holding = 0;
      end
    end
  end

  // Compare process: every cycle on the falling edge.
  always @(negedge clk) begin
    check("allowin", {31'h0, mem_allowin}, {31'h0, !m_holding || (!m_loading && wb_allowin)});
    check("mem_valid", {31'h0, mem_valid}, {31'h0, m_holding && !m_loading});
    check("data_req", {31'h0, data_req}, {31'h0, m_loading});
    check("hi_out", hi_out, m_hi);
    check("lo_out", lo_out, m_lo);
    if (m_loading) check("data_addr", data_addr, m_addr);
    if (m_holding && !m_loading) begin
      check("reg_en", {31'h0, mem_reg_en}, {31'h0, m_en});
      check("reg_waddr", {26'h0, mem_reg_waddr}, {26'h0, m_waddr});
      check("reg_wdata", mem_reg_wdata, m_wdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction until accepted (bounded); returns the stall count.
  task automatic send(input logic rd, input logic [2:0] op, input logic [5:0] wa,
                      input logic [31:0] alu, input logic dbl, input logic [31:0] hi,
                      input logic [31:0] lo, output int waits);
    exe_valid = 1; exe_mem_read = rd; exe_mem_op = op; exe_reg_en = 1; exe_reg_waddr = wa;
    exe_alu_result = alu; exe_double_en = dbl; exe_HI_wdata = hi; exe_LO_wdata = lo;
    waits = 0;
    #1;
    while (!mem_allowin && waits < 20) begin
      cyc();
      waits++;
    end
    if (!mem_allowin) check("accept_timeout", 32'd0, 32'd1);
    cyc();
    exe_valid = 0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    int          k;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t lv[9] = '{
    '{3'd1, 32'h103, 3, 32'hFFFF_FF80},
    '{3'd2, 32'h103, 0, 32'h0000_0080},
    '{3'd4, 32'h102, 1, 32'h0000_80FF},
    '{3'd3, 32'h102, 2, 32'hFFFF_80FF},
    '{3'd1, 32'h100, 0, 32'h0000_0022},
    '{3'd3, 32'h101, 1, 32'h0000_1122},
    '{3'd0, 32'h103, 2, 32'h80FF_1122},
    '{3'd7, 32'h100, 0, 32'h80FF_1122},
    '{3'd2, 32'h101, 4, 32'h0000_0011}
  };

  initial begin
    int w;
    resetn = 0; exe_valid = 0; exe_reg_en = 0; exe_mem_read = 0; exe_double_en = 0;
    exe_mem_op = 0; exe_reg_waddr = 0; exe_alu_result = 0; exe_HI_wdata = 0; exe_LO_wdata = 0;
    data_ack = 0; data_rdata = RDATA; wb_allowin = 1;
    cyc();
    check("rst_waddr", {26'h0, mem_reg_waddr}, 32'd0);
    check("rst_wdata", mem_reg_wdata, 32'd0);
    check("rst_addr", data_addr, 32'd0);
    check("rst_hi", hi_out, INIT);
    cyc();
    resetn = 1;
    cyc();

    // Non-load pass-through.
    send(0, 3'd0, 6'd5, 32'h1234, 0, 0, 0, w);
    check("nl_valid", {31'h0, mem_valid}, 32'd1);
    check("nl_wdata", mem_reg_wdata, 32'h1234);
    check("nl_waddr", {26'h0, mem_reg_waddr}, 32'd5);
    cyc();

    // Loads with varying types, offsets and ack latencies.
    foreach (lv[i]) begin
      send(1, lv[i].op, 6'd9, lv[i].addr, 0, 0, 0, w);
      check("ld_addr", data_addr, lv[i].addr & 32'hFFFF_FFFC);
      repeat (lv[i].k) cyc();
      data_ack = 1;
      cyc();
      data_ack = 0;
      check("ld_valid", {31'h0, mem_valid}, 32'd1);
      check("ld_wdata", mem_reg_wdata, lv[i].exp);
    end
    cyc();

    // Stray ack while idle must do nothing.
    data_ack = 1;
    cyc();
    data_ack = 0;
    check("stray_ack", {31'h0, mem_valid}, 32'd0);

    // Backpressure then back-to-back acceptance.
    wb_allowin = 0;
    send(0, 3'd0, 6'd7, 32'h77, 0, 0, 0, w);
    repeat (4) begin
      check("bp_allowin", {31'h0, mem_allowin}, 32'd0);
      check("bp_wdata", mem_reg_wdata, 32'h77);
      cyc();
    end
    wb_allowin = 1;
    send(0, 3'd0, 6'd8, 32'h88, 0, 0, 0, w);
    check("b2b_waits", w, 32'd0);
    check("b2b_valid", {31'h0, mem_valid}, 32'd1);
    check("b2b_wdata", mem_reg_wdata, 32'h88);
    cyc();

    // HI/LO commit on consume; double_en=0 leaves them alone.
    send(0, 3'd0, 6'd1, 32'h1, 1, 32'hA, 32'hB, w);
    cyc();
    check("hi_write", hi_out, 32'hA);
    check("lo_write", lo_out, 32'hB);
    send(0, 3'd0, 6'd1, 32'h2, 0, 32'hC, 32'hD, w);
    cyc();
    cyc();
    check("hi_hold", hi_out, 32'hA);
    check("lo_hold", lo_out, 32'hB);

    // Reset during an outstanding load, stale ack right after release.
    send(1, 3'd0, 6'd3, 32'h200, 0, 0, 0, w);
    cyc();
    resetn = 0;
    #1;
    check("rw_req", {31'h0, data_req}, 32'd0);
    check("rw_valid", {31'h0, mem_valid}, 32'd0);
    cyc();
    cyc();
    resetn = 1;
    data_ack = 1;
    cyc();
    data_ack = 0;
    check("rr_valid", {31'h0, mem_valid}, 32'd0);
    check("rr_req", {31'h0, data_req}, 32'd0);
    check("rr_hi", hi_out, INIT);
    check("rr_lo", lo_out, INIT);
    send(0, 3'd0, 6'd2, 32'h55, 0, 0, 0, w);
    check("rr_accept", w, 32'd0);
    check("rr_wdata", mem_reg_wdata, 32'h55);
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter HILO_INIT SHALL be declared: default 32'h0; reset value of both the HI and LO registers.
REQ-002 clk  input  1  sole clock; every register SHALL update on its rising edge.
REQ-003 resetn  input  1  reset; the block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 exe_valid  input  1  execute stage presents an instruction this cycle.
REQ-005 exe_reg_en, exe_mem_read, exe_double_en  input  1 each  register-write enable, load flag, HI/LO write flag.
REQ-006 exe_mem_op  input  3  load type: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; any other code SHALL be treated as LW.
REQ-007 exe_reg_waddr  input  6  destination register number.
REQ-008 exe_alu_result, exe_HI_wdata, exe_LO_wdata  input  32 each  ALU result or load address; HI/LO write data.
REQ-009 mem_allowin  output  1  the stage accepts an instruction this cycle.
REQ-010 data_req  output  1; data_addr  output  32; data_ack  input  1; data_rdata  input  32  variable-latency data-memory read port.
REQ-011 wb_allowin  input  1  the writeback stage accepts a result this cycle.
REQ-012 mem_valid, mem_reg_en  output  1 each; mem_reg_waddr  output  6; mem_reg_wdata  output  32  result presented to writeback.
REQ-013 hi_out, lo_out  output  32 each  architectural HI and LO registers.

Function
REQ-014 The FSM SHALL have three states: IDLE (empty), WAIT (load outstanding), DONE (result valid).
REQ-015 mem_allowin SHALL equal (state==IDLE) | (state==DONE & wb_allowin) and SHALL depend combinationally on wb_allowin only.
REQ-016 Accept = exe_valid & mem_allowin; on accept the stage SHALL latch every exe_* field.
REQ-017 On accept with exe_mem_read=1, next state SHALL be WAIT, with data_req=1 and data_addr={exe_alu_result[31:2],2'b00} registered.
REQ-018 On accept with exe_mem_read=0, next state SHALL be DONE and mem_reg_wdata SHALL be the latched exe_alu_result.
REQ-019 In WAIT, data_req and data_addr SHALL hold steady until the cycle data_ack=1; on that edge data_req SHALL drop, aligned data SHALL be captured, and the state SHALL go to DONE.
REQ-020 data_ack SHALL be honoured in the first cycle data_req is high; data_ack outside WAIT SHALL be ignored.
REQ-021 Alignment (off = latched addr[1:0]): LB/LBU SHALL select byte data_rdata[8*off+7:8*off]; LH/LHU SHALL select halfword off[1]; LW SHALL take the full word.
REQ-022 LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend; misaligned LH/LW SHALL ignore the low address bits, with no exception.
REQ-023 mem_valid SHALL be 1 exactly in DONE; mem_reg_en, mem_reg_waddr and mem_reg_wdata SHALL be stable while mem_valid=1 and wb_allowin=0.
REQ-024 Latency: a non-load accepted at edge N SHALL show mem_valid in cycle N+1; a load acked k cycles after data_req rises SHALL show mem_valid in cycle N+2+k.
REQ-025 Consume = DONE & wb_allowin; on consume with no simultaneous accept, the next state SHALL be IDLE.
REQ-026 On simultaneous consume and accept, the new instruction SHALL be loaded with no bubble (DONE->DONE or DONE->WAIT).
REQ-027 On consume with the latched double_en=1, hi_out<=HI_wdata and lo_out<=LO_wdata SHALL take effect on that edge; otherwise HI/LO SHALL hold.
REQ-028 In WAIT, mem_allowin SHALL be 0 and upstream SHALL stall; exe_valid without accept SHALL leave the state unchanged.

Reset
REQ-029 While resetn=0, the state SHALL be IDLE and mem_valid, data_req, mem_reg_en SHALL be 0, with mem_reg_waddr=0, mem_reg_wdata=0, data_addr=0, and hi_out=lo_out=HILO_INIT.
REQ-030 Reset asserted in WAIT SHALL abandon the load; a stale data_ack after reset release SHALL be ignored, and the stage SHALL accept in the first cycle after release.

Verification
REQ-031 Non-load: exe_alu_result=32'h1234, reg_en=1, waddr=5, wb_allowin=1 -> next cycle mem_valid=1, mem_reg_wdata=32'h1234, mem_reg_waddr=5.
REQ-032 LB at addr 32'h103, data_rdata=32'h80FF_1122, ack after 3 cycles -> data_addr=32'h100, wdata=32'hFFFF_FF80; LBU -> 32'h80; LHU at 32'h102 -> 32'h80FF.
REQ-033 Backpressure: wb_allowin=0 for 4 cycles in DONE -> outputs held, mem_allowin=0; then wb_allowin=1 with exe_valid=1 -> back-to-back acceptance, no bubble.
REQ-034 double_en=1, HI_wdata=32'hA, LO_wdata=32'hB, consumed -> hi_out=32'hA and lo_out=32'hB the next cycle; a double_en=0 instruction leaves them unchanged.
REQ-035 Reset pulse during WAIT, then data_ack=1 after release -> state IDLE, mem_valid=0, data_req=0, HI/LO=HILO_INIT.
